// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - EX operand forwarding and load-use stall control
//
// Purpose: selects the ALU operand sources in EX. Stalls IF/ID and bubbles ID/EX
//          for LOAD_LAT cycles when a load result is consumed in ID.
//          A taken-branch flush aborts a pending stall.
//          Optional macro FWD_WB_BYPASS_EN enables the WB-to-decode bypass.
// Parameters: REG_ADDR_W register specifier width, LOAD_LAT stall cycles per
//          hazard (1..7), CNT_W stall-cycle counter width.
// Inputs:  clk, rst (async active-high), ID specifiers/qualifiers, ID/EX,
//          EX/MEM and MEM/WB destinations, flush.
// Outputs: fwd_a/fwd_b operand selects, stall, bubble, byp_rs/byp_rt,
//          stall_cycles saturating counter.
module forward_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_regwrite,
    input  logic                  flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall,
    output logic                  bubble,
    output logic                  byp_rs,
    output logic                  byp_rt,
    output logic [CNT_W-1:0]      stall_cycles
);

    typedef enum logic {IDLE, WAIT} state_t;

    // First cycle of each stall is spent in IDLE, so WAIT covers LOAD_LAT-1 cycles.
    localparam logic [2:0] CNT_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              hazard;
    logic              stall_raw;
    logic [1:0]        fwd_a_raw, fwd_b_raw;
    logic              byp_rs_raw, byp_rt_raw;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input logic [REG_ADDR_W-1:0] m_rd,
                                           input logic                  m_we,
                                           input logic [REG_ADDR_W-1:0] w_rd,
                                           input logic                  w_we);
        // EX/MEM is younger than MEM/WB, so it is checked first.
        if (m_we && (m_rd != '0) && (m_rd == src))
            return 2'd2;
        else if (w_we && (w_rd != '0) && (w_rd == src))
            return 2'd1;
        else
            return 2'd0;
    endfunction

    always_comb begin
        fwd_a_raw = fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_b_raw = fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    end

`ifdef FWD_WB_BYPASS_EN
    always_comb begin
        byp_rs_raw = wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs) && id_uses_rs;
        byp_rt_raw = wb_regwrite && (wb_rd != '0) && (wb_rd == id_rt) && id_uses_rt;
    end
`else
    // Register file writes in the first half-cycle, so decode never needs a bypass.
    always_comb begin
        byp_rs_raw = 1'b0;
        byp_rt_raw = 1'b0;
    end
`endif

    always_comb begin
        hazard = id_valid && ex_memread && ex_regwrite && (ex_rd != '0) &&
                 ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (hazard && !flush) begin
                    stall_raw = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                // EX already holds the bubble here, so the hazard term is ignored.
                stall_raw = 1'b1;
                if (flush || (cnt_q == 3'd0))
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_raw && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 3'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Every output reads zero while reset is held, combinational ones included.
    always_comb begin
        fwd_a        = rst ? 2'd0 : fwd_a_raw;
        fwd_b        = rst ? 2'd0 : fwd_b_raw;
        stall        = !rst && stall_raw;
        bubble       = !rst && stall_raw;
        byp_rs       = !rst && byp_rs_raw;
        byp_rt       = !rst && byp_rt_raw;
        stall_cycles = rst ? '0 : stall_cycles_q;
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - directed self-checking bench for forward_hazard_unit
module tb_forward_hazard_unit;

    localparam int RW = 5;
    localparam int LL = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_rs, id_uses_rt;
    logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic          ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, flush;
    logic [1:0]    fwd_a, fwd_b;
    logic          stall, bubble, byp_rs, byp_rt;
    logic [CW-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    forward_hazard_unit #(.REG_ADDR_W(RW), .LOAD_LAT(LL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .bubble(bubble),
        .byp_rs(byp_rs), .byp_rt(byp_rt), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_rs = 0; id_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0; flush = 0;
    endtask

    task automatic set_load_use();
        id_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 5;
        id_rs = 5; id_uses_rs = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        #3;
        rst = 0;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        // Forwarding inputs active during reset: outputs must still read zero.
        ex_rs = 3; mem_rd = 3; mem_regwrite = 1;
        set_load_use();
        #2;
        check("rst_fwd_a", fwd_a, 0);
        check("rst_stall", stall, 0);
        check("rst_cnt", stall_cycles, 0);
        clear_inputs();
        tick();
        rst = 0;
        tick();

        // Back-to-back ALU dependency: EX/MEM beats MEM/WB.
        ex_rs = 3; mem_rd = 3; mem_regwrite = 1; wb_rd = 3; wb_regwrite = 1;
        #1;
        check("fwd_a_exmem", fwd_a, 2);
        check("fwd_b_none", fwd_b, 0);
        mem_regwrite = 0;
        #1;
        check("fwd_a_memwb", fwd_a, 1);
        ex_rt = 3;
        #1;
        check("fwd_b_memwb", fwd_b, 1);

        // Register 0 never forwarded or hazarded.
        clear_inputs();
        mem_rd = 0; ex_rt = 0; mem_regwrite = 1; wb_rd = 0; wb_regwrite = 1;
        #1;
        check("fwd_b_r0", fwd_b, 0);
        clear_inputs();
        id_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
        #1;
        check("stall_r0", stall, 0);

        // Load-use: exactly LL stall cycles.
        clear_inputs();
        set_load_use();
        #1;
        check("lu_stall_c1", stall, 1);
        check("lu_bubble_c1", bubble, 1);
        tick();
        id_valid = 0;
        #1;
        check("lu_stall_c2", stall, 1);
        tick();
        check("lu_stall_c3", stall, 1);
        check("lu_bubble_c3", bubble, 1);
        tick();
        check("lu_stall_end", stall, 0);
        check("lu_bubble_end", bubble, 0);
        check("lu_cnt", stall_cycles, 3);

        // id_uses_rt qualifier.
        clear_inputs();
        id_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 5;
        id_rs = 1; id_uses_rs = 1; id_rt = 5; id_uses_rt = 0;
        #1;
        check("no_use_rt", stall, 0);
        id_uses_rt = 1;
        #1;
        check("use_rt", stall, 1);

        // Flush in the same cycle as H wins and keeps the FSM in IDLE.
        flush = 1;
        #1;
        check("flush_h_stall", stall, 0);
        check("flush_h_bubble", bubble, 0);
        tick();
        clear_inputs();
        #1;
        check("flush_h_idle", stall, 0);
        check("flush_h_cnt", stall_cycles, 3);

        // Flush in the first WAIT cycle aborts the remaining stall.
        set_load_use();
        #1;
        check("fw_c1", stall, 1);
        tick();
        clear_inputs();
        flush = 1;
        #1;
        check("fw_c2", stall, 1);
        tick();
        flush = 0;
        #1;
        check("fw_after", stall, 0);
        check("fw_cnt", stall_cycles, 5);

        // Reset pulsed in the 2nd stall cycle.
        set_load_use();
        ex_rs = 3; mem_rd = 3; mem_regwrite = 1;
        tick();
        id_valid = 0;
        #1;
        check("rp_c2", stall, 1);
        rst = 1;
        #1;
        check("rp_stall", stall, 0);
        check("rp_bubble", bubble, 0);
        check("rp_fwd_a", fwd_a, 0);
        check("rp_cnt", stall_cycles, 0);
        rst = 0;
        #1;
        check("rp_fwd_a_rel", fwd_a, 2);
        tick();
        check("rp_idle", stall, 0);
        check("rp_cnt_idle", stall_cycles, 0);

        // Saturation: 2^CW+5 continuous stall cycles.
        clear_inputs();
        set_load_use();
        for (int i = 0; i < 10; i++) tick();
        check("sat_mid", stall_cycles, 10);
        for (int i = 0; i < (1 << CW) + 5 - 10; i++) tick();
        check("sat_hold", stall_cycles, (1 << CW) - 1);
        check("sat_stall", stall, 1);

        // Decode write-back bypass.
        clear_inputs();
        do_reset();
        wb_rd = 7; wb_regwrite = 1; id_rt = 7; id_uses_rt = 1; id_rs = 7; id_uses_rs = 0;
        #1;
`ifdef FWD_WB_BYPASS_EN
        check("byp_rt", byp_rt, 1);
`else
        check("byp_rt", byp_rt, 0);
`endif
        check("byp_rs_unused", byp_rs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
